// File: rtl/div_result_bcd_formatter.sv
// Converts the divider's signed quotient/remainder into sign + BCD digits.
// Serial double dabble, one bit per clock: quotient first, then remainder.
module div_result_bcd_formatter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic [WIDTH-1:0]      Quotient,
   input  logic [WIDTH-1:0]      Remainder,
   input  logic                  DivByZero,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  Error,
   output logic                  QSign,
   output logic [4*DIGITS-1:0]   QBCD,
   output logic                  RSign,
   output logic [4*DIGITS-1:0]   RBCD
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned SH_W  = BCD_W + WIDTH;

   typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, FINISH} state_t;

   state_t             state, next_state;
   logic [CNT_W-1:0]   cnt;
   logic [BCD_W-1:0]   acc;
   logic [BCD_W-1:0]   q_hold;
   logic [WIDTH-1:0]   mag;
   logic [WIDTH-1:0]   r_mag;
   logic               q_neg, r_neg, dz;

   logic               accept_c, last_c;
   logic [BCD_W-1:0]   adj_c, acc_next_c;
   logic [WIDTH-1:0]   mag_next_c;
   logic [SH_W-1:0]    shift_c;

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? WIDTH'(~v + WIDTH'(1)) : v;
   endfunction

   always_ff @(posedge CLOCK) begin
      if (RESET) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept_c   = 1'b0;
      last_c     = (cnt == CNT_W'(WIDTH - 1));
      case (state)
         IDLE: begin
            if (START) begin
               next_state = CONV_Q;
               accept_c   = 1'b1;
            end
         end
         CONV_Q: if (last_c) next_state = CONV_R;
         CONV_R: if (last_c) next_state = FINISH;
         FINISH: begin
            if (START) begin
               next_state = CONV_Q;
               accept_c   = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // One double-dabble step: add 3 to every nibble >= 5, then shift left.
   always_comb begin
      adj_c = acc;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (acc[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
      shift_c    = {adj_c, mag} << 1;
      acc_next_c = shift_c[SH_W-1:WIDTH];
      mag_next_c = shift_c[WIDTH-1:0];
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         cnt    <= '0;
         acc    <= '0;
         q_hold <= '0;
         mag    <= '0;
         r_mag  <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         dz     <= 1'b0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         Error  <= 1'b0;
         QSign  <= 1'b0;
         QBCD   <= '0;
         RSign  <= 1'b0;
         RBCD   <= '0;
      end else begin
         DONE <= 1'b0;
         if (accept_c) begin
            mag   <= mag_of(Quotient);
            r_mag <= mag_of(Remainder);
            q_neg <= Quotient[WIDTH-1];
            r_neg <= Remainder[WIDTH-1];
            dz    <= DivByZero;
            acc   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
         end else if (state == CONV_Q || state == CONV_R) begin
            cnt <= last_c ? '0 : cnt + CNT_W'(1);
            if (last_c && state == CONV_Q) begin
               q_hold <= acc_next_c;
               acc    <= '0;
               mag    <= r_mag;
            end else begin
               acc <= acc_next_c;
               mag <= mag_next_c;
            end
            // Publish all results together on entry to FINISH.
            if (last_c && state == CONV_R) begin
               BUSY  <= 1'b0;
               DONE  <= 1'b1;
               Error <= dz;
               if (dz) begin
                  QSign <= 1'b0;
                  RSign <= 1'b0;
                  QBCD  <= {BCD_W{1'b1}};
                  RBCD  <= {BCD_W{1'b1}};
               end else begin
                  QSign <= q_neg;
                  RSign <= r_neg;
                  QBCD  <= q_hold;
                  RBCD  <= acc_next_c;
               end
            end
         end
      end
   end

endmodule

// File: doc/div_result_bcd_formatter.md
Name: div_result_bcd_formatter

Overview:
- Stage directly downstream of the signed 8-bit divider; consumes its Quotient/Remainder when the divider raises DONE.
- Converts each signed two's-complement result into a sign flag plus unsigned BCD digits for the calculator's 7-segment display driver.
- Sequential shift-and-add-3 (double dabble), one bit per clock; quotient first, then remainder.
- START/DONE handshake in the same style as the divider.

Parameters:
- WIDTH, 8, operand width of Quotient and Remainder (two's complement).
- DIGITS, 3, BCD digits per result; must satisfy 10^DIGITS > 2^(WIDTH-1).

Ports:
- CLOCK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  capture request; wire to the divider's DONE.
- Quotient  input  WIDTH  signed quotient from the divider.
- Remainder  input  WIDTH  signed remainder from the divider.
- DivByZero  input  1  divisor-was-zero flag; sampled together with START.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse; result outputs valid from this cycle onward.
- Error  output  1  latched divide-by-zero indication for the current result.
- QSign  output  1  1 = quotient negative.
- QBCD  output  4*DIGITS  quotient magnitude digits, most significant digit in the top nibble.
- RSign  output  1  1 = remainder negative.
- RBCD  output  4*DIGITS  remainder magnitude digits, same digit ordering as QBCD.

Behaviour:
- States: IDLE, CONV_Q, CONV_R, FINISH.
- Reset (synchronous): state goes to IDLE; BUSY, DONE, Error, QSign and RSign go to 0; QBCD and RBCD go to 0; bit counter and scratch registers are cleared.
  - Reset wins over START in the same cycle.
  - Reset mid-conversion abandons the conversion; no DONE is produced.
- IDLE, START sampled high:
  - Latch Quotient, Remainder and DivByZero.
  - Compute magnitude = value[WIDTH-1] ? -value : value, treated as WIDTH-bit unsigned. The most negative value maps to 2^(WIDTH-1), e.g. 0x80 -> 128.
  - Latch both sign bits, clear the BCD accumulator and counter, go to CONV_Q, BUSY=1.
- CONV_Q, one bit per cycle for WIDTH cycles:
  - Every BCD nibble >= 5 gets +3.
  - Then {BCD accumulator, magnitude} shifts left by 1.
  - After the WIDTH-th shift, store the accumulator to a quotient holding register, clear the accumulator, load the remainder magnitude and go to CONV_R.
- CONV_R: identical procedure on the remainder magnitude for WIDTH cycles, then go to FINISH.
- FINISH:
  - Update QSign, QBCD, RSign, RBCD and Error together.
  - If the latched DivByZero = 1: Error=1, QBCD and RBCD all nibbles 4'hF (blank code), QSign=RSign=0.
  - DONE=1 and BUSY=0 for this single cycle.
  - If START is high in FINISH, accept it as in IDLE (back-to-back operation); otherwise return to IDLE.
- Latency: START high in cycle c -> DONE high in cycle c+2*WIDTH+1 (c+17 at default parameters). Latency is fixed and independent of data and of DivByZero.
- START while in CONV_Q or CONV_R is ignored; latched operands are not disturbed.
- Changes on the Quotient/Remainder inputs after capture have no effect.
- All result outputs hold their values from one FINISH until the next FINISH or until reset. They never show partial results.
- No BCD nibble ever exceeds 9 except the 4'hF error code.

Test Plan:
- Reset, then Quotient=0x07, Remainder=0x02, START 1 cycle -> DONE exactly 17 cycles later; QSign=0, QBCD=0x007, RSign=0, RBCD=0x002; BUSY high for the 16 intervening cycles.
- Quotient=0x80, Remainder=0x00 -> QSign=1, QBCD=0x128, RSign=0, RBCD=0x000.
- Quotient=0xF3 (-13), Remainder=0xFF (-1) -> QSign=1, QBCD=0x013, RSign=1, RBCD=0x001. Also Quotient=0x7F -> QBCD=0x127.
- DivByZero=1 with START -> DONE at the same latency; Error=1, QBCD=RBCD=0xFFF, both signs 0. A following valid conversion clears Error.
- START pulsed again 5 cycles after the first with different operands -> ignored; a single DONE with the first operands' result. START held high in the FINISH cycle -> second conversion starts, second DONE 17 cycles later.
- RESET asserted 8 cycles into a conversion -> next cycle BUSY=0, all outputs 0; no DONE appears; a subsequent START converts normally.
